alu_op_driver: RTL and testbench
================================

ALU_OP_DRIVER -- requirements
Module: alu_op_driver

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  driver can accept a request.
REQ-007 req_op  input  4  requested ALU opcode.
REQ-008 req_a, req_b  input  32 each  operands.
REQ-009 alu_a, alu_b  output  32 each  registered operands to the combinational ALU.
REQ-010 alu_opcode  output  4  registered opcode to the ALU.
REQ-011 alu_result  input  32  ALU result.
REQ-012 alu_negative, alu_zero  input  1 each  ALU flags.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_result  output  32  captured result.
REQ-016 rsp_negative, rsp_zero  output  1 each  captured flags.
REQ-017 rsp_illegal  output  1  request carried an undefined opcode.
REQ-018 flag_n, flag_z  output  1 each  flags of the last legal completed operation.
REQ-019 op_count  output  COUNT_W  number of legal operations completed.

Function
REQ-020 SHALL treat these opcodes as legal: 0000 ADD, 0001 INC, 0010 NEG, 0011 SUB, 0100 PASSA; every other opcode SHALL be illegal.
REQ-021 SHALL have exactly three FSM states: IDLE, SETTLE and RESP.
REQ-022 In IDLE: req_ready=1 and rsp_valid=0.
REQ-023 In SETTLE and RESP: req_ready=0.
REQ-024 IDLE, req_valid=1, legal opcode: register req_a, req_b and req_op onto alu_a, alu_b and alu_opcode; go to SETTLE.
REQ-025 SETTLE lasts exactly one cycle; at its end, capture alu_result, alu_negative and alu_zero into the rsp_* outputs; go to RESP.
REQ-026 Legal-operation latency: accept edge T gives rsp_valid=1 after edge T+2.
REQ-027 IDLE, req_valid=1, illegal opcode: leave alu_* unchanged and go directly to RESP with rsp_illegal=1 and rsp_result=0, rsp_negative=0, rsp_zero=0; rsp_valid=1 after edge T+1.
REQ-028 The ALU SHALL never be driven with an illegal opcode.
REQ-029 In RESP: rsp_valid=1; rsp_* and alu_* SHALL hold stable until rsp_valid and rsp_ready are both 1.
REQ-030 On the RESP handshake: go to IDLE and clear rsp_valid on the same edge.
REQ-031 On a legal handshake: load flag_n and flag_z from rsp_negative and rsp_zero, and increment op_count.
REQ-032 On an illegal handshake: leave flag_n, flag_z and op_count unchanged.
REQ-033 op_count SHALL wrap from all-ones to 0 without any other effect.
REQ-034 rsp_illegal SHALL clear on the edge that accepts the next request.
REQ-035 Back-to-back throughput SHALL be at most one request per 3 cycles, or per 2 cycles for illegal opcodes.
REQ-036 req_valid while not in IDLE SHALL be ignored; the requester holds the request until req_ready=1.

Reset
REQ-037 rst=1 at any edge SHALL force IDLE and clear rsp_valid, rsp_*, flag_n, flag_z, op_count, alu_a and alu_b to 0.
REQ-038 Reset SHALL set alu_opcode to 0100 (PASSA).
REQ-039 Reset during SETTLE or RESP SHALL abandon the operation with no response and no counter or flag update; rsp_valid=0 after that edge.
REQ-040 When rst and a handshake coincide on the same edge, rst SHALL win.

Structure
REQ-041 The opcode constants, the legal-opcode set and the state encoding SHALL live in shared package alu_pkg, shared with the ALU.
REQ-042 alu_op_driver SHALL connect to the ALU through ports only and SHALL NOT instantiate it.
REQ-043 One sub-module is natural: wrap_counter (parameter COUNT_W, synchronous clear, enable), used for op_count.

Verification
REQ-044 ADD: A=5, B=7, rsp_ready=1 -> rsp_valid after T+2 with result 0x0000000C, N=0, Z=0; op_count=1.
REQ-045 SUB: A=3, B=3 -> result 0, Z=1, N=0; afterwards flag_z=1.
REQ-046 NEG: A=1 -> result 0xFFFFFFFF, N=1. Next, opcode 1111 -> rsp_illegal=1 after T+1; alu_opcode stays 0010; flag_n stays 1; op_count unchanged.
REQ-047 Backpressure: rsp_ready=0 for 3 cycles during an INC of 0xFFFFFFFF -> rsp_result stays 0 with Z=1 and req_ready=0 throughout; handshake on cycle 4, then IDLE.
REQ-048 Reset mid-op: rst asserted in SETTLE -> no rsp_valid, op_count unchanged, alu_opcode=0100.
REQ-049 Wrap: COUNT_W=4, 16 legal operations -> op_count returns to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operation driver: opcode constants,
// the legal-opcode set and the driver state encoding.
package alu_pkg;

    // ALU opcodes understood by the combinational ALU
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_INC   = 4'b0001;
    localparam logic [3:0] OP_NEG   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_PASSA = 4'b0100;

    // Opcode parked on the ALU after reset; it is harmless and legal
    localparam logic [3:0] RESET_OPCODE = OP_PASSA;

    // Driver FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } drv_state_e;

    // True when the opcode belongs to the legal set
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal_s;
        case (op)
            OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_PASSA: legal_s = 1'b1;
            default:                                  legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running modulo-2^COUNT_W event counter with synchronous clear and
// count enable. Wraps from all-ones to zero silently.
module wrap_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] count_r;

    // Count register: clear has priority over enable
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + COUNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/alu_op_driver.sv
// Request/response front end for a combinational ALU. Legal requests are
// registered onto the ALU, given one cycle to settle, then the result and
// flags are captured and offered as a response. Illegal opcodes never reach
// the ALU and are answered directly with a zero result.
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [31:0]        req_a,
    input  logic [31:0]        req_b,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_opcode,
    input  logic [31:0]        alu_result,
    input  logic               alu_negative,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic               rsp_negative,
    output logic               rsp_zero,
    output logic               rsp_illegal,
    output logic               flag_n,
    output logic               flag_z,
    output logic [COUNT_W-1:0] op_count
);

    drv_state_e state_r;
    drv_state_e state_nxt_s;

    logic       op_legal_s;
    logic       accept_s;
    logic       accept_legal_s;
    logic       settle_done_s;
    logic       handshake_s;
    logic       hs_legal_s;

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [31:0]       alu_a_r;
    logic [31:0]       alu_b_r;
    logic [3:0]        alu_opcode_r;
    logic [31:0]       rsp_result_r;
    logic              rsp_negative_r;
    logic              rsp_zero_r;
    logic              rsp_illegal_r;
    logic              flag_n_r;
    logic              flag_z_r;
    logic [COUNT_W-1:0] op_count_s;

    // Next-state decode and per-cycle event strobes
    always_comb begin
        state_nxt_s    = state_r;
        op_legal_s     = is_legal_op(req_op);
        accept_s       = 1'b0;
        accept_legal_s = 1'b0;
        settle_done_s  = 1'b0;
        handshake_s    = 1'b0;
        hs_legal_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s       = 1'b1;
                    accept_legal_s = op_legal_s;
                    if (op_legal_s) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                settle_done_s = 1'b1;
                state_nxt_s   = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    handshake_s = 1'b1;
                    hs_legal_s  = ~rsp_illegal_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake outputs follow the next state so they are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // ALU operand registers and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r        <= 32'd0;
            alu_b_r        <= 32'd0;
            alu_opcode_r   <= RESET_OPCODE;
            rsp_result_r   <= 32'd0;
            rsp_negative_r <= 1'b0;
            rsp_zero_r     <= 1'b0;
            rsp_illegal_r  <= 1'b0;
        end else if (accept_s && accept_legal_s) begin
            alu_a_r       <= req_a;
            alu_b_r       <= req_b;
            alu_opcode_r  <= req_op;
            rsp_illegal_r <= 1'b0;
        end else if (accept_s) begin
            // Illegal opcode: ALU inputs untouched, answer with zeros
            rsp_result_r   <= 32'd0;
            rsp_negative_r <= 1'b0;
            rsp_zero_r     <= 1'b0;
            rsp_illegal_r  <= 1'b1;
        end else if (settle_done_s) begin
            rsp_result_r   <= alu_result;
            rsp_negative_r <= alu_negative;
            rsp_zero_r     <= alu_zero;
        end else begin
            rsp_result_r   <= rsp_result_r;
            rsp_negative_r <= rsp_negative_r;
            rsp_zero_r     <= rsp_zero_r;
        end
    end

    // Sticky flags of the last legal operation the consumer accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else if (handshake_s && hs_legal_s) begin
            flag_n_r <= rsp_negative_r;
            flag_z_r <= rsp_zero_r;
        end else begin
            flag_n_r <= flag_n_r;
            flag_z_r <= flag_z_r;
        end
    end

    wrap_counter #(
        .COUNT_W (COUNT_W)
    ) u_op_counter (
        .clk   (clk),
        .clr   (rst),
        .en    (hs_legal_s),
        .count (op_count_s)
    );

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_opcode   = alu_opcode_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_negative = rsp_negative_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_illegal  = rsp_illegal_r;
    assign flag_n       = flag_n_r;
    assign flag_z       = flag_z_r;
    assign op_count     = op_count_s;

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: directed scenarios followed by
// randomized operations checked against a transaction-level reference model.
module tb_alu_op_driver;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [3:0]    alu_opcode;
    logic [31:0]   alu_result;
    logic          alu_negative;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_negative;
    logic          rsp_zero;
    logic          rsp_illegal;
    logic          flag_n;
    logic          flag_z;
    logic [CW-1:0] op_count;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model state
    int          cnt_m;
    logic        fn_m;
    logic        fz_m;
    logic [3:0]  last_op_m;
    logic [31:0] last_a_m;
    logic [31:0] last_b_m;

    alu_op_driver #(.COUNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_negative (rsp_negative),
        .rsp_zero     (rsp_zero),
        .rsp_illegal  (rsp_illegal),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic meaning of each opcode
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a + 32'd1;
            4'd2:    return 32'd0 - a;
            4'd3:    return a - b;
            4'd4:    return a;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural combinational ALU attached to the driver
    always_comb begin
        alu_result   = alu_fn(alu_opcode, alu_a, alu_b);
        alu_negative = alu_result[31];
        alu_zero     = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        cnt_m     = 0;
        fn_m      = 1'b0;
        fz_m      = 1'b0;
        last_op_m = 4'd4;
        last_a_m  = 32'd0;
        last_b_m  = 32'd0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'(cnt_m));
        chk({tag, "_flag_n"}, 32'(flag_n), 32'(fn_m));
        chk({tag, "_flag_z"}, 32'(flag_z), 32'(fz_m));
    endtask

    // One full request/response transaction with `stall` cycles of backpressure
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        int          waited;
        logic        legal;
        logic [31:0] exp_r;
        logic        exp_n;
        logic        exp_z;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        legal = (op <= 4'd4);
        exp_r = legal ? alu_fn(op, a, b) : 32'd0;
        exp_n = legal ? exp_r[31] : 1'b0;
        exp_z = legal ? (exp_r == 32'd0) : 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (stall == 0);
        tick();
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        if (legal) begin
            last_op_m = op;
            last_a_m  = a;
            last_b_m  = b;
            chk("settle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("settle_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        chk("alu_opcode", 32'(alu_opcode), 32'(last_op_m));
        chk("alu_a", alu_a, last_a_m);
        chk("alu_b", alu_b, last_b_m);
        chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_illegal", 32'(rsp_illegal), 32'(!legal));
        chk("resp_result", rsp_result, exp_r);
        chk("resp_neg", 32'(rsp_negative), 32'(exp_n));
        chk("resp_zero", 32'(rsp_zero), 32'(exp_z));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_result", rsp_result, exp_r);
            chk("stall_zero", 32'(rsp_zero), 32'(exp_z));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_alu_opcode", 32'(alu_opcode), 32'(last_op_m));
        end
        rsp_ready = 1'b1;
        tick();
        if (legal) begin
            cnt_m = (cnt_m + 1) % (1 << CW);
            fn_m  = exp_n;
            fz_m  = exp_z;
        end
        check_idle("after_hs");
    endtask

    initial begin
        logic [3:0] rop;
        int         r;
        int         cnt_start;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_idle("reset");
        chk("reset_alu_opcode", 32'(alu_opcode), 32'd4);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);

        // Directed scenarios
        run_op(4'd0, 32'd5, 32'd7, 0);
        chk("add_count_one", 32'(op_count), 32'd1);
        run_op(4'd3, 32'd3, 32'd3, 0);
        chk("sub_flag_z", 32'(flag_z), 32'd1);
        run_op(4'd2, 32'd1, 32'd0, 0);
        run_op(4'd15, 32'h1234_5678, 32'h9abc_def0, 0);
        chk("illegal_keeps_opcode", 32'(alu_opcode), 32'd2);
        chk("illegal_keeps_flag_n", 32'(flag_n), 32'd1);
        run_op(4'd1, 32'hFFFF_FFFF, 32'd0, 3);

        // Reset while the operation is settling
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 32'd10;
        req_b     = 32'd20;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_idle("rst_settle");
        chk("rst_settle_opcode", 32'(alu_opcode), 32'd4);
        chk("rst_settle_alu_a", alu_a, 32'd0);
        tick();
        chk("rst_settle_no_rsp", 32'(rsp_valid), 32'd0);

        // Counter wrap with 16 legal operations
        cnt_start = cnt_m;
        for (int i = 0; i < 16; i++) begin
            run_op(4'($urandom_range(0, 4)), $urandom, $urandom, 0);
        end
        chk("wrap_count", 32'(op_count), 32'(cnt_start));

        // Randomized mix of legal and illegal opcodes with backpressure
        for (int i = 0; i < 30; i++) begin
            r   = int'($urandom_range(0, 9));
            rop = (r < 5) ? 4'(r) : 4'(r + 5);
            run_op(rop, $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        // Reset coinciding with a legal response handshake
        run_op(4'd4, 32'h8000_0000, 32'd0, 0);
        req_valid = 1'b1;
        req_op    = 4'd4;
        req_a     = 32'h8000_0000;
        req_b     = 32'd0;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("coincide_in_resp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_idle("rst_handshake");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
